// File: rtl/core_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   - forward-select encodings for the EX-stage ALU source muxes
//   - hazard FSM state encoding
//   - shadow pipeline entry structs and a register-match helper
package core_pkg;

    // Width of register indices held in shadow entries; REG_AW must not exceed it.
    localparam int unsigned RIDX_W = 5;
    localparam int unsigned FWD_W  = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MC_WAIT    = 2'd2
    } hz_state_e;

    // Destination tracking kept for every stage past ID.
    typedef struct packed {
        logic              valid;
        logic [RIDX_W-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } shadow_t;

    // The EX entry additionally keeps its source indices and the multi-cycle flag.
    typedef struct packed {
        shadow_t           dst;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
        logic              multicycle;
    } ex_entry_t;

    // True when a valid entry targets a non-zero register equal to idx.
    function automatic logic rd_hit(input logic              valid,
                                    input logic [RIDX_W-1:0] rd,
                                    input logic [RIDX_W-1:0] idx);
        return valid && (rd != '0) && (rd == idx);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EX-stage ALU source.
//   src   : register index read by the EX instruction
//   mem   : MEM shadow entry
//   wb    : WB shadow entry
//   sel_c : FWD_MEM / FWD_WB / FWD_RF, combinational
module fwd_sel
    import core_pkg::*;
(
    input  logic [RIDX_W-1:0] src,
    input  shadow_t           mem,
    input  shadow_t           wb,
    output logic [FWD_W-1:0]  sel_c
);

    // Load flags play no part in forwarding.
    logic unused_load_flags;
    assign unused_load_flags = mem.mem_read ^ wb.mem_read;

    // The younger (MEM) producer wins over WB.
    always_comb begin
        sel_c = FWD_RF;
        if (mem.reg_write && rd_hit(mem.valid, mem.rd, src)) begin
            sel_c = FWD_MEM;
        end else if (wb.reg_write && rd_hit(wb.valid, wb.rd, src)) begin
            sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Tracks EX/MEM/WB destinations in shadow entries, drives the EX ALU source
// forward selects, and generates stall/bubble controls for load-use (or RAW)
// hazards and multi-cycle EX operations.
//
// Build option: HAZARD_FWD_EN
//   defined   - forwarding from MEM/WB, only load-use hazards stall
//   undefined - forward selects tied to register file, any EX/MEM RAW stalls
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_valid, id_rs1/2, id_rs1/2_used, id_rd,
//   id_reg_write, id_mem_read, id_multicycle   ID-stage instruction info
//   flush                           taken branch in EX, kills IF/ID
//   mc_done                         multi-cycle result ready pulse
//   mc_start                        multi-cycle launch pulse
//   pc_write, ifid_write, idex_write  0 = hold the corresponding register
//   idex_bubble, exmem_bubble       insert NOP into ID/EX or EX/MEM
//   forward_a, forward_b            ALU source selects
// Control outputs are combinational from registered state and ID inputs.
module hazard_fwd_ctrl
    import core_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_multicycle,
    input  logic              flush,
    input  logic              mc_done,
    output logic              mc_start,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic [FWD_W-1:0]  forward_a,
    output logic [FWD_W-1:0]  forward_b
);

    hz_state_e         state_q;
    hz_state_e         state_nx;
    ex_entry_t         ex_q;
    shadow_t           mem_q;
    shadow_t           wb_q;
    ex_entry_t         id_entry;
    logic [RIDX_W-1:0] id_src1;
    logic [RIDX_W-1:0] id_src2;
    logic              data_hazard;
    logic              mc_launch;

    assign id_src1 = RIDX_W'(id_rs1);
    assign id_src2 = RIDX_W'(id_rs2);

    // ID payload as it lands in the EX entry.
    always_comb begin
        id_entry               = '0;
        id_entry.dst.valid     = id_valid;
        id_entry.dst.rd        = RIDX_W'(id_rd);
        id_entry.dst.reg_write = id_reg_write;
        id_entry.dst.mem_read  = id_mem_read;
        id_entry.rs1           = id_src1;
        id_entry.rs2           = id_src2;
        id_entry.multicycle    = id_multicycle;
    end

`ifdef HAZARD_FWD_EN
    logic ex_rd_read;

    // Only a load in EX cannot be forwarded in time.
    always_comb begin
        ex_rd_read  = (id_rs1_used && rd_hit(ex_q.dst.valid, ex_q.dst.rd, id_src1)) ||
                      (id_rs2_used && rd_hit(ex_q.dst.valid, ex_q.dst.rd, id_src2));
        data_hazard = id_valid && ex_q.dst.mem_read && ex_rd_read;
    end

    fwd_sel u_fwd_a (
        .src   (ex_q.rs1),
        .mem   (mem_q),
        .wb    (wb_q),
        .sel_c (forward_a)
    );

    fwd_sel u_fwd_b (
        .src   (ex_q.rs2),
        .mem   (mem_q),
        .wb    (wb_q),
        .sel_c (forward_b)
    );
`else
    logic raw_ex;
    logic raw_mem;
    logic unused_fwd_state;

    // Without forwarding, any pending EX/MEM writer of a used source stalls;
    // WB is safe because the register file writes before it is read.
    always_comb begin
        raw_ex  = ex_q.dst.reg_write &&
                  ((id_rs1_used && rd_hit(ex_q.dst.valid, ex_q.dst.rd, id_src1)) ||
                   (id_rs2_used && rd_hit(ex_q.dst.valid, ex_q.dst.rd, id_src2)));
        raw_mem = mem_q.reg_write &&
                  ((id_rs1_used && rd_hit(mem_q.valid, mem_q.rd, id_src1)) ||
                   (id_rs2_used && rd_hit(mem_q.valid, mem_q.rd, id_src2)));
        data_hazard = id_valid && (raw_ex || raw_mem);
    end

    assign forward_a        = FWD_RF;
    assign forward_b        = FWD_RF;
    assign unused_fwd_state = ^{ex_q.rs1, ex_q.rs2, mem_q.mem_read, wb_q};
`endif

    // A multi-cycle op launches on its first EX cycle; in MC_WAIT it is already running.
    assign mc_launch = (state_q != MC_WAIT) && ex_q.dst.valid && ex_q.multicycle;

    // Hazard FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next state and stall/bubble controls. LOAD_STALL marks the cycle after a
    // bubble and evaluates hazards exactly like RUN so back-to-back cases still stall.
    always_comb begin
        state_nx     = state_q;
        mc_start     = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        unique case (state_q)
            RUN, LOAD_STALL: begin
                state_nx = RUN;
                if (mc_launch) begin
                    // Launch cycle already counts as a stall cycle.
                    mc_start     = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    state_nx     = MC_WAIT;
                end else if (flush) begin
                    // Killed ID instruction cannot cause a stall.
                    idex_bubble = 1'b1;
                end else if (data_hazard) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_nx    = LOAD_STALL;
                end
            end
            MC_WAIT: begin
                if (mc_done) begin
                    state_nx = RUN;
                end else begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // Shadow entries; a bubble only clears valid, the rest of the payload still moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q.dst;
            if (exmem_bubble) begin
                mem_q.valid <= 1'b0;
            end
            if (idex_write) begin
                ex_q <= id_entry;
                if (idex_bubble) begin
                    ex_q.dst.valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed testbench for hazard_fwd_ctrl. Expectations adapt to HAZARD_FWD_EN.
module tb_hazard_fwd_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_multicycle;
    logic       flush;
    logic       mc_done;
    logic       mc_start;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_write;
    logic       idex_bubble;
    logic       exmem_bubble;
    logic [1:0] forward_a;
    logic [1:0] forward_b;

    int errors;
    int checks;

    hazard_fwd_ctrl #(.REG_AW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_rd         (id_rd),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_multicycle (id_multicycle),
        .flush         (flush),
        .mc_done       (mc_done),
        .mc_start      (mc_start),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .idex_write    (idex_write),
        .idex_bubble   (idex_bubble),
        .exmem_bubble  (exmem_bubble),
        .forward_a     (forward_a),
        .forward_b     (forward_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mc);
        id_valid      = v;
        id_rs1        = rs1;
        id_rs1_used   = u1;
        id_rs2        = rs2;
        id_rs2_used   = u2;
        id_rd         = rd;
        id_reg_write  = rw;
        id_mem_read   = mr;
        id_multicycle = mc;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        flush   = 1'b0;
        mc_done = 1'b0;
        repeat (4) next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drain();
        settle();
        checks++; if (mc_start !== 1'b0) begin errors++; $display("FAIL rst_mc_start: got %b want 0", mc_start); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write: got %b want 1", pc_write); end
        checks++; if (ifid_write !== 1'b1) begin errors++; $display("FAIL rst_ifid_write: got %b want 1", ifid_write); end
        checks++; if (idex_write !== 1'b1) begin errors++; $display("FAIL rst_idex_write: got %b want 1", idex_write); end
        checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL rst_idex_bubble: got %b want 0", idex_bubble); end
        checks++; if (exmem_bubble !== 1'b0) begin errors++; $display("FAIL rst_exmem_bubble: got %b want 0", exmem_bubble); end
        checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL rst_forward_a: got %b want 00", forward_a); end
        checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL rst_forward_b: got %b want 00", forward_b); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_forwarding();
        logic [1:0] exp;
        drain();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);  // A: writes x5
        next_cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);  // B: writes x5
        next_cycle();
        set_id(1'b1, 5'd5, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);  // C: reads x5, x7
        next_cycle();
        // EX=C, MEM=B(x5), WB=A(x5)
        set_id(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);  // D: reads x5, x5
        settle();
        exp = FWD_EN ? 2'b10 : 2'b00;
        checks++; if (forward_a !== exp) begin errors++; $display("FAIL fwd_mem_over_wb: got %b want %b", forward_a, exp); end
        checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL fwd_b_nomatch: got %b want 00", forward_b); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL fwd_unused_no_stall: got %b want 1", pc_write); end
        next_cycle();
        // EX=D, MEM=C (no write), WB=B(x5)
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        exp = FWD_EN ? 2'b01 : 2'b00;
        checks++; if (forward_a !== exp) begin errors++; $display("FAIL fwd_wb_a: got %b want %b", forward_a, exp); end
        checks++; if (forward_b !== exp) begin errors++; $display("FAIL fwd_wb_b: got %b want %b", forward_b, exp); end
        next_cycle();
    endtask

    task automatic test_x0();
        drain();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);  // writes x0
        next_cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);  // writes x0
        next_cycle();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);  // reads x0, x0
        settle();
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL x0_no_stall: got %b want 1", pc_write); end
        checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL x0_no_bubble: got %b want 0", idex_bubble); end
        next_cycle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL x0_forward_a: got %b want 00", forward_a); end
        checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL x0_forward_b: got %b want 00", forward_b); end
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [1:0] exp;
        logic       exp1;
        drain();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);  // lw x3
        next_cycle();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);  // add x4, x3
        settle();
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL lu_pc_write: got %b want 0", pc_write); end
        checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL lu_ifid_write: got %b want 0", ifid_write); end
        checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL lu_idex_bubble: got %b want 1", idex_bubble); end
        checks++; if (idex_write !== 1'b1) begin errors++; $display("FAIL lu_idex_write: got %b want 1", idex_write); end
        checks++; if (exmem_bubble !== 1'b0) begin errors++; $display("FAIL lu_exmem_bubble: got %b want 0", exmem_bubble); end
        next_cycle();
        settle();
        exp  = FWD_EN ? 2'b10 : 2'b00;
        exp1 = FWD_EN ? 1'b1 : 1'b0;
        checks++; if (forward_a !== exp) begin errors++; $display("FAIL lu_next_forward_a: got %b want %b", forward_a, exp); end
        checks++; if (pc_write !== exp1) begin errors++; $display("FAIL lu_next_pc_write: got %b want %b", pc_write, exp1); end
        checks++; if (idex_bubble !== !exp1) begin errors++; $display("FAIL lu_next_idex_bubble: got %b want %b", idex_bubble, !exp1); end
        next_cycle();
        settle();
        exp = FWD_EN ? 2'b01 : 2'b00;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_release_pc_write: got %b want 1", pc_write); end
        checks++; if (forward_a !== exp) begin errors++; $display("FAIL lu_wb_forward_a: got %b want %b", forward_a, exp); end
        next_cycle();
    endtask

    task automatic test_multicycle();
        drain();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);  // mul x6
        next_cycle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++; if (mc_start !== 1'b1) begin errors++; $display("FAIL mc_start_pulse: got %b want 1", mc_start); end
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL mc_start_pc_write: got %b want 0", pc_write); end
        checks++; if (idex_write !== 1'b0) begin errors++; $display("FAIL mc_start_idex_write: got %b want 0", idex_write); end
        checks++; if (exmem_bubble !== 1'b1) begin errors++; $display("FAIL mc_start_exmem_bubble: got %b want 1", exmem_bubble); end
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            settle();
            checks++; if (mc_start !== 1'b0) begin errors++; $display("FAIL mc_wait%0d_mc_start: got %b want 0", i, mc_start); end
            checks++; if (exmem_bubble !== 1'b1) begin errors++; $display("FAIL mc_wait%0d_exmem_bubble: got %b want 1", i, exmem_bubble); end
            checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL mc_wait%0d_ifid_write: got %b want 0", i, ifid_write); end
        end
        next_cycle();
        mc_done = 1'b1;
        settle();
        checks++; if (exmem_bubble !== 1'b0) begin errors++; $display("FAIL mc_done_exmem_bubble: got %b want 0", exmem_bubble); end
        checks++; if (idex_write !== 1'b1) begin errors++; $display("FAIL mc_done_idex_write: got %b want 1", idex_write); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL mc_done_pc_write: got %b want 1", pc_write); end
        checks++; if (mc_start !== 1'b0) begin errors++; $display("FAIL mc_done_mc_start: got %b want 0", mc_start); end
        next_cycle();
        mc_done = 1'b0;
        settle();
        checks++; if (mc_start !== 1'b0) begin errors++; $display("FAIL mc_after_no_relaunch: got %b want 0", mc_start); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL mc_after_pc_write: got %b want 1", pc_write); end
        next_cycle();
        mc_done = 1'b1;  // stray pulse while running
        settle();
        checks++; if (exmem_bubble !== 1'b0) begin errors++; $display("FAIL mc_stray_exmem_bubble: got %b want 0", exmem_bubble); end
        next_cycle();
        mc_done = 1'b0;
        settle();
        checks++; if (idex_write !== 1'b1) begin errors++; $display("FAIL mc_stray_idex_write: got %b want 1", idex_write); end
        next_cycle();
    endtask

    task automatic test_flush_load_use();
        drain();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);  // lw x3
        next_cycle();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);  // add x4, x3
        flush = 1'b1;
        settle();
        checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL flush_idex_bubble: got %b want 1", idex_bubble); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL flush_pc_write: got %b want 1", pc_write); end
        checks++; if (ifid_write !== 1'b1) begin errors++; $display("FAIL flush_ifid_write: got %b want 1", ifid_write); end
        next_cycle();
        flush = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL flush_after_idex_bubble: got %b want 0", idex_bubble); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL flush_after_pc_write: got %b want 1", pc_write); end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        next_cycle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        settle();
        checks++; if (idex_write !== 1'b0) begin errors++; $display("FAIL rmid_pre_idex_write: got %b want 0", idex_write); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rmid_pc_write: got %b want 1", pc_write); end
        checks++; if (ifid_write !== 1'b1) begin errors++; $display("FAIL rmid_ifid_write: got %b want 1", ifid_write); end
        checks++; if (idex_write !== 1'b1) begin errors++; $display("FAIL rmid_idex_write: got %b want 1", idex_write); end
        checks++; if (exmem_bubble !== 1'b0) begin errors++; $display("FAIL rmid_exmem_bubble: got %b want 0", exmem_bubble); end
        checks++; if (mc_start !== 1'b0) begin errors++; $display("FAIL rmid_mc_start: got %b want 0", mc_start); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        mc_done = 1'b1;
        settle();
        checks++; if (exmem_bubble !== 1'b0) begin errors++; $display("FAIL rmid_late_done_exmem: got %b want 0", exmem_bubble); end
        checks++; if (mc_start !== 1'b0) begin errors++; $display("FAIL rmid_late_done_mc_start: got %b want 0", mc_start); end
        next_cycle();
        mc_done = 1'b0;
        settle();
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rmid_after_pc_write: got %b want 1", pc_write); end
        next_cycle();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        flush   = 1'b0;
        mc_done = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_forwarding();
        test_x0();
        test_load_use();
        test_multicycle();
        test_flush_load_use();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
